// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions N_BTN raw push-switch inputs: two-flop synchronizer, counter
//   debouncer, registered press/release pulses, and an optional per-channel
//   auto-repeat FSM (IDLE -> DELAY -> REPEAT) for channels in REPEAT_MASK.
//
// Ports
//   clk          board clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   btn_raw      raw switch levels (asynchronous), 1 = pressed
//   btn_level    debounced level per channel, 1 = pressed
//   btn_pulse    one-cycle pulse per press or auto-repeat event
//   btn_release  one-cycle pulse when the debounced level falls
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned      N_BTN           = 6,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter int unsigned      REPEAT_DELAY    = 12500000,
    parameter int unsigned      REPEAT_PERIOD   = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(6'b001100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RC_W    = $clog2(REP_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        localparam bit MASKED = REPEAT_MASK[i];

        logic            sync_1, sync_2;
        logic            level_q, pulse_q, release_q;
        logic [DB_W-1:0] db_cnt;
        logic            toggle, rise, fall;
        rep_state_t      state_q, state_d;
        logic [RC_W-1:0] rc_q, rc_d;
        logic            rep_due;

        // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
        assign toggle = (sync_2 != level_q) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        assign rise   = toggle & ~level_q;
        assign fall   = toggle &  level_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_1    <= 1'b0;
                sync_2    <= 1'b0;
                db_cnt    <= '0;
                level_q   <= 1'b0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_1 <= btn_raw[i];
                sync_2 <= sync_1;
                if ((sync_2 == level_q) || toggle)
                    db_cnt <= '0;
                else
                    db_cnt <= db_cnt + DB_W'(1);
                if (toggle)
                    level_q <= ~level_q;
                // Pulses are registered alongside the level so they coincide
                // with the first cycle the new level is visible.
                pulse_q   <= rise | rep_due;
                release_q <= fall;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                rc_q    <= '0;
            end else begin
                state_q <= state_d;
                rc_q    <= rc_d;
            end
        end

        // The FSM reacts to the rise/fall events of the same edge, so the
        // counter starts with the press pulse and a falling level takes
        // priority over a repeat that is due on that edge.
        always_comb begin
            state_d = state_q;
            rc_d    = rc_q;
            rep_due = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise && MASKED) begin
                        state_d = DELAY;
                        rc_d    = '0;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state_d = IDLE;
                        rc_d    = '0;
                    end else if (rc_q == RC_W'(REPEAT_DELAY - 1)) begin
                        rep_due = 1'b1;
                        state_d = REPEAT;
                        rc_d    = '0;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_d = IDLE;
                        rc_d    = '0;
                    end else if (rc_q == RC_W'(REPEAT_PERIOD - 1)) begin
                        rep_due = 1'b1;
                        rc_d    = '0;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rc_d    = '0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_pulse[i]   = pulse_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 6; number of push-button channels, bit i = push_switch(i+1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000; consecutive disagreeing cycles required to change a debounced level, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 12500000; cycles from press pulse to first auto-repeat pulse, minimum 2.
REQ-004 Parameter REPEAT_PERIOD, default 2500000; cycles between subsequent auto-repeat pulses, minimum 2.
REQ-005 Parameter REPEAT_MASK, default 6'b001100; channels with auto-repeat enabled (up/down).
REQ-006 clk  input  1  board clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 btn_raw  input  N_BTN  raw push-switch levels, asynchronous, 1 = pressed.
REQ-009 btn_level  output  N_BTN  debounced level per channel, 1 = pressed.
REQ-010 btn_pulse  output  N_BTN  one-cycle pulse per press event or auto-repeat event.
REQ-011 btn_release  output  N_BTN  one-cycle pulse when debounced level falls.

Function
REQ-012 Each channel SHALL pass btn_raw through a two-flop synchronizer before any other logic.
REQ-013 Each channel SHALL keep a debounce counter: cleared whenever synchronized input equals btn_level; incremented otherwise.
REQ-014 btn_level SHALL toggle on the DEBOUNCE_CYCLES-th consecutive edge of disagreement, with the counter cleared in that cycle; raw-to-level latency = DEBOUNCE_CYCLES + 2 edges.
REQ-015 Disagreement shorter than DEBOUNCE_CYCLES cycles (glitch/bounce) SHALL leave btn_level, btn_pulse, btn_release unchanged.
REQ-016 btn_pulse[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 1 after a 0->1 transition; btn_release[i] likewise on 1->0.
REQ-017 All outputs SHALL be registered; no combinational path from btn_raw to any output.
REQ-018 Repeat FSM per masked channel, states IDLE, DELAY, REPEAT, with one counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-019 IDLE->DELAY on the press-pulse cycle, counter cleared.
REQ-020 In DELAY, btn_pulse SHALL assert REPEAT_DELAY cycles after the press pulse, and the FSM SHALL enter REPEAT with the counter cleared.
REQ-021 In REPEAT, btn_pulse SHALL assert every REPEAT_PERIOD cycles while btn_level stays 1.
REQ-022 When btn_level falls, in DELAY or REPEAT, the FSM SHALL return to IDLE on the next edge with no further pulse; a repeat due in that same cycle SHALL be suppressed.
REQ-023 Unmasked channels SHALL never leave IDLE and SHALL produce exactly one btn_pulse per press.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all appear in the same cycle.
REQ-025 Counters SHALL saturate or clear; no wrap-around SHALL produce a spurious pulse at any parameter value.

Reset
REQ-026 While reset = 1: synchronizer flops, btn_level, btn_pulse, btn_release, all counters = 0; all FSMs = IDLE.
REQ-027 A button held through reset deassertion SHALL be re-debounced and SHALL yield one btn_pulse DEBOUNCE_CYCLES + 2 edges after deassertion.
REQ-028 Reset asserted mid-repeat SHALL clear outputs asynchronously within the same cycle, with no pulse emitted during reset.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 btn_raw[0] 0->1 steady -> btn_level[0] rises 6 edges later; btn_pulse[0] high exactly 1 cycle; no repeats (unmasked); release after 6 edges -> one btn_release[0].
REQ-030 btn_raw[1] bounces 1,0,1,1,0,1 per cycle then settles at 1 -> no output until 4 stable synchronized cycles; exactly one pulse.
REQ-031 btn_raw[2] held 30 cycles -> pulses at press cycle P, P+10, P+13, P+16, ...; release -> btn_release[2], no further pulse.
REQ-032 btn_raw[2] released exactly when a repeat is due -> no pulse that cycle; FSM in IDLE on the next edge.
REQ-033 btn_raw[0] and btn_raw[3] pressed on the same edge -> btn_pulse = 6'b001001 in one cycle.
REQ-034 reset pulsed while btn_raw[3] is held in REPEAT -> outputs 0 immediately; after deassertion, new press pulse at 6 edges, first repeat 10 cycles later.
